// File: rtl/serial_frame_serializer.sv
// ---------------------------------------------------------------------------
// serial_frame_serializer
//
// Transmit end of a serial shift-register link. A WIDTH-bit staging register
// (Q) is written one bit at a time or in parallel. A start request snapshots Q
// into a separate shifter. The snapshot is then sent MSB-first as {S, enable}
// strobes. A receiver that shifts left and inserts S on each enable ends up
// holding a copy of the snapshot.
//
// Optional feature (compile-time macro SERIAL_PARITY_EN):
//   When defined, one even-parity bit (XOR of the snapshot) follows the data
//   bits. That bit is also sent with enable=1, and hold stalls it as well.
//   When undefined, a frame is exactly WIDTH strobes.
//
// Parameters
//   WIDTH   frame length in bits; must equal 2**ADDR_W
//   ADDR_W  width of the bit-address port
//
// Ports
//   clk        in   1       clock; all state updates on posedge
//   reset      in   1       synchronous, active-high reset
//   wr_en      in   1       write a single staging bit: Q[addr] <= wr_bit
//   addr       in   ADDR_W  bit index for wr_en
//   wr_bit     in   1       bit value for wr_en
//   load_en    in   1       parallel load Q <= load_data (wins over wr_en)
//   load_data  in   WIDTH   parallel load value
//   start      in   1       request transmission of the current Q (IDLE only)
//   hold       in   1       downstream stall; freezes shifting while high
//   enable     out  1       registered strobe: S is valid, receiver shifts
//   S          out  1       registered serial data bit (holds when enable=0)
//   busy       out  1       high while in SHIFT or DONE
//   done       out  1       one-cycle pulse the cycle after the last strobe
// ---------------------------------------------------------------------------
module serial_frame_serializer #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_bit,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              start,
  input  logic              hold,
  output logic              enable,
  output logic              S,
  output logic              busy,
  output logic              done
);

  // The bit counter needs one extra bit so it can reach WIDTH when the
  // parity bit is appended.
  localparam int CNT_W = ADDR_W + 1;

`ifdef SERIAL_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shifter;
  logic [CNT_W-1:0] count;

`ifdef SERIAL_PARITY_EN
  logic             parity;
`endif

  // Decoded per-cycle events.
  logic             take_start;
  logic             emit;
  logic             last_emit;
  logic             s_bit;

  // Next values for the registered outputs.
  logic             enable_nxt;
  logic             s_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // start is only acted on in IDLE; any start seen in SHIFT/DONE is dropped.
  assign take_start = (state == IDLE) && start;
  assign emit       = (state == SHIFT) && !hold;
  assign last_emit  = emit && (count == LAST_CNT);

  // After WIDTH data bits have been sent, the shifter is empty. In the
  // parity build, the next strobe carries the parity captured at snapshot time.
`ifdef SERIAL_PARITY_EN
  assign s_bit = (count == CNT_W'(WIDTH)) ? parity : shifter[WIDTH-1];
`else
  assign s_bit = shifter[WIDTH-1];
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take_start) state_nxt = SHIFT;
      SHIFT:   if (last_emit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    enable_nxt = 1'b0;
    s_nxt      = S;
    done_nxt   = 1'b0;
    busy_nxt   = (state_nxt != IDLE);
    unique case (state)
      IDLE: begin
        enable_nxt = 1'b0;
      end
      SHIFT: begin
        if (emit) begin
          enable_nxt = 1'b1;
          s_nxt      = s_bit;
        end
      end
      DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        enable_nxt = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      S      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      enable <= enable_nxt;
      S      <= s_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Staging register: written in every state. It is double-buffered against
  // the shifter, so a write never disturbs a frame in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (wr_en) begin
      q[addr] <= wr_bit;
    end
  end

  // -------------------------------------------------------------------------
  // Shifter and bit counter. The snapshot reads q before this edge's write
  // lands, so a start and a write in the same cycle send the old contents.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter <= '0;
      count   <= '0;
    end else if (take_start) begin
      shifter <= q;
      count   <= '0;
    end else if (emit) begin
      shifter <= {shifter[WIDTH-2:0], 1'b0};
      count   <= count + 1'b1;
    end
  end

`ifdef SERIAL_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (take_start) begin
      parity <= ^q;
    end
  end
`endif

endmodule
